// File: rtl/clock_select.sv
// -----------------------------------------------------------------------------
// clock_select
//   Prescaler for the 8-bit timer. Derives the timer count clock clk_in from
//   pclk at pclk/2, /4, /8 or /16, chosen by cks. A new ratio is adopted only
//   when the prescale counter wraps to zero. On that edge every divided phase
//   is low at once, so switching never produces a runt pulse.
//
//   Ports
//     pclk     in   system clock, rising-edge
//     preset   in   synchronous active-high reset
//     cks      in   [1:0] ratio request (00=/2, 01=/4, 10=/8, 11=/16)
//     clk_in   out  divided clock, registered, 50% duty
//     clk_tick out  (CLOCK_SELECT_TICK_EN only) one-pclk pulse on the same
//                   edge that clk_in rises
//
//   Parameters
//     RESET_SEL     ratio selection loaded on reset
//
//   Build option
//     `define CLOCK_SELECT_TICK_EN to add the clk_tick output.
// -----------------------------------------------------------------------------
module clock_select #(
  parameter logic [1:0] RESET_SEL = 2'b00
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic [1:0] cks,
  output logic       clk_in
`ifdef CLOCK_SELECT_TICK_EN
  ,
  output logic       clk_tick
`endif
);

  logic [3:0] cnt;
  logic [3:0] nxt;
  logic [1:0] sel;
  logic       wrap;
  logic       clk_nxt;

  // Bit k of a free-running binary counter is a square wave of period 2^(k+1).
  // All bits are zero together on the wrap, which makes that edge the only
  // safe point to change which bit drives the output.
  always_comb begin
    nxt     = cnt + 4'd1;
    wrap    = (cnt == 4'hF);
    clk_nxt = nxt[sel];
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      cnt    <= 4'd0;
      sel    <= RESET_SEL;
      clk_in <= 1'b0;
    end else begin
      cnt    <= nxt;
      clk_in <= clk_nxt;
      // Only the request present on the wrap edge is adopted; requests seen
      // on any other edge are ignored.
      if (wrap) sel <= cks;
    end
  end

`ifdef CLOCK_SELECT_TICK_EN
  // Rising edge of clk_in: the registered output is about to go 0 -> 1.
  always_ff @(posedge pclk) begin
    if (preset) clk_tick <= 1'b0;
    else        clk_tick <= clk_nxt & ~clk_in;
  end
`endif

endmodule

// File: tb/tb_clock_select.sv
// -----------------------------------------------------------------------------
// tb_clock_select
//   Directed stimulus for clock_select. Every pclk edge the stimulus process
//   pushes the expected clk_in (and clk_tick when built with
//   CLOCK_SELECT_TICK_EN) into a queue; the monitor pops and compares on the
//   following falling edge.
//   The reference uses the half-period view: with ratio s and edge count t
//   since the last reset, the output is high when (t mod 2^(s+1)) >= 2^s.
//   Ratio changes are scheduled on every 16th edge after reset.
// -----------------------------------------------------------------------------
module tb_clock_select;

  localparam logic [1:0] RST_SEL = 2'b00;

  logic       pclk = 1'b0;
  logic       preset;
  logic [1:0] cks;
  logic       clk_in;
`ifdef CLOCK_SELECT_TICK_EN
  logic       clk_tick;
`endif

  always #10 pclk = ~pclk;

  clock_select #(.RESET_SEL(RST_SEL)) dut (
    .pclk   (pclk),
    .preset (preset),
    .cks    (cks),
    .clk_in (clk_in)
`ifdef CLOCK_SELECT_TICK_EN
    ,
    .clk_tick(clk_tick)
`endif
  );

  typedef struct {
    logic clk;
    logic tick;
    int   edge_no;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   edge_cnt = 0;

  // reference state
  int   t     = 0;      // edges since reset, modulo 16
  int   msel  = 0;      // ratio currently in force
  logic prev  = 1'b0;   // previous expected clk_in

  // Apply one edge worth of inputs and push what the DUT must show after it.
  task automatic step(input logic [1:0] c, input logic r);
    exp_t e;
    int   period;
    cks    = c;
    preset = r;
    @(posedge pclk);
    #1;
    edge_cnt++;
    if (r) begin
      t      = 0;
      msel   = int'(RST_SEL);
      e.clk  = 1'b0;
      e.tick = 1'b0;
    end else begin
      logic wrap_edge;
      wrap_edge = (t == 15);
      t      = (t + 1) % 16;
      period = 2 << msel;
      e.clk  = ((t % period) >= (period / 2));
      e.tick = e.clk & ~prev;
      if (wrap_edge) msel = int'(c);
    end
    prev      = e.clk;
    e.edge_no = edge_cnt;
    q.push_back(e);
  endtask

  task automatic run(input logic [1:0] c, input int n);
    for (int i = 0; i < n; i++) step(c, 1'b0);
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (clk_in !== e.clk) begin
          fails++;
          $display("FAIL clk_in edge %0d: got %b expected %b", e.edge_no, clk_in, e.clk);
        end
`ifdef CLOCK_SELECT_TICK_EN
        tests++;
        if (clk_tick !== e.tick) begin
          fails++;
          $display("FAIL clk_tick edge %0d: got %b expected %b", e.edge_no, clk_tick, e.tick);
        end
`endif
      end
    end
  end

  // stimulus
  initial begin
    int guard;
    preset = 1'b1;
    cks    = 2'b00;

    // reset held for three edges; output must stay low
    for (int i = 0; i < 3; i++) step(2'b00, 1'b1);

    // /2 straight out of reset: 1,0,1,0...
    run(2'b00, 10);

    // request /4 mid-period; stays /2 until the wrap, then 2 low / 2 high
    run(2'b01, 30);

    // /8 then /16
    run(2'b10, 40);
    run(2'b11, 48);

    // glitchy request between wraps: only the value at the wrap edge counts
    guard = 0;
    while (t != 3 && guard < 32) begin
      step(2'b11, 1'b0);
      guard++;
    end
    step(2'b00, 1'b0);
    step(2'b11, 1'b0);
    step(2'b00, 1'b0);
    step(2'b01, 1'b0);
    step(2'b00, 1'b0);
    run(2'b11, 40);

    // reset during a high phase with /16 active
    guard = 0;
    while (prev != 1'b1 && guard < 32) begin
      step(2'b11, 1'b0);
      guard++;
    end
    step(2'b11, 1'b1);
    // RESET_SEL (/2) must be back in force until the next wrap loads /8
    run(2'b10, 40);

    // request /2 back and finish with a second reset sequence
    run(2'b00, 20);
    step(2'b01, 1'b1);
    step(2'b01, 1'b1);
    run(2'b01, 24);

    // drain: every pushed expectation must have been checked
    repeat (2) @(negedge pclk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations unchecked, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
